// File: rtl/ic_bd_pkg.sv
// Shared constants, floor-shift helper and lane vector type for the BinDCT-C7 stage.
package ic_bd_pkg;
  localparam int N_PTS = 8;
  localparam int MAX_W = 32;

  localparam int SH1 = 1;
  localparam int SH2 = 2;
  localparam int SH3 = 3;
  localparam int SH4 = 4;
  localparam int SH6 = 6;

  // Coefficients are carried sign-extended to MAX_W between the datapath and the narrowing lanes.
  typedef logic [N_PTS-1:0][MAX_W-1:0] coef_vec_t;

  function automatic logic signed [MAX_W-1:0] asr(input logic signed [MAX_W-1:0] v, input int n);
    return v >>> n;
  endfunction
endpackage

// File: rtl/ic_bd_narrow.sv
// One output lane: brings a sign-extended coefficient down to OUT_W bits.
// With IC_BD_SAT_EN defined it clamps and reports the clamp; otherwise it wraps.
module ic_bd_narrow
  import ic_bd_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic [MAX_W-1:0] d,
  output logic [OUT_W-1:0] q
`ifdef IC_BD_SAT_EN
  ,
  output logic             clamp
`endif
);

`ifdef IC_BD_SAT_EN
  logic fits;

  // Representable iff every bit from the OUT_W sign position upward matches the sign.
  assign fits  = (d[MAX_W-1:OUT_W-1] == {(MAX_W-OUT_W+1){d[MAX_W-1]}});
  assign clamp = !fits;

  always_comb begin
    q = d[OUT_W-1:0];
    if (!fits) begin
      if (d[MAX_W-1]) q = {1'b1, {(OUT_W-1){1'b0}}};
      else            q = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^d[MAX_W-1:OUT_W];
  assign q         = d[OUT_W-1:0];
`endif

endmodule

// File: rtl/ic_bd_bindct_1d_pipe.sv
// Three-stage 8-point forward BinDCT-C7 with valid/ready flow control and a block-end sideband.
// Optional clamp-on-narrowing plus sticky sat_flag when IC_BD_SAT_EN is defined.
module ic_bd_bindct_1d_pipe
  import ic_bd_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = IN_W + 4,
  parameter int LVL_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [8*IN_W-1:0]    x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [8*OUT_W-1:0]   y
`ifdef IC_BD_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam int IW = IN_W + 4;
  typedef logic signed [IW-1:0] iw_t;

  function automatic iw_t sr(input iw_t v, input int n);
    logic signed [MAX_W-1:0] w;
    w = asr(MAX_W'(v), n);
    return w[IW-1:0];
  endfunction

  function automatic iw_t ext(input logic [IN_W-1:0] s);
    if (LVL_SHIFT != 0) return iw_t'({4'b0000, s}) - iw_t'(1 << (IN_W - 1));
    else                return IW'(signed'(s));
  endfunction

  // A single enable stalls the whole pipe; bubbles travel with it rather than collapsing.
  // Valid/ready: a vector moves on a clock edge where valid and ready are both high.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  iw_t xs [N_PTS];
  iw_t a  [N_PTS];
  logic s1_v, s1_l;

  always_comb begin
    for (int k = 0; k < N_PTS; k++) xs[k] = ext(x[k*IN_W +: IN_W]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
      s1_l <= 1'b0;
    end else if (en) begin
      s1_v <= in_valid;
      s1_l <= in_valid && in_last;
      a[0] <= xs[0] + xs[7];
      a[7] <= xs[0] - xs[7];
      a[1] <= xs[1] + xs[6];
      a[6] <= xs[1] - xs[6];
      a[2] <= xs[2] + xs[5];
      a[5] <= xs[2] - xs[5];
      a[3] <= xs[3] + xs[4];
      a[4] <= xs[3] - xs[4];
    end
  end

  iw_t t15, t16;
  iw_t e0, e1, e2, e3, o4, o5, o6, o7;
  logic s2_v, s2_l;

  always_comb begin
    t15 = sr(a[6], SH1) + sr(a[6], SH3) - sr(a[5], SH1) - sr(a[5], SH2) - sr(a[5], SH6);
    t16 = a[6] + sr(a[5], SH2) + sr(a[5], SH3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v <= 1'b0;
      s2_l <= 1'b0;
    end else if (en) begin
      s2_v <= s1_v;
      s2_l <= s1_l;
      e0   <= a[0] + a[3];
      e1   <= a[1] + a[2];
      e2   <= a[1] - a[2];
      e3   <= a[0] - a[3];
      o4   <= a[4] + t15;
      o5   <= a[4] - t15;
      o6   <= a[7] - t16;
      o7   <= a[7] + t16;
    end
  end

  iw_t xc [N_PTS];
  coef_vec_t xv;
  logic [N_PTS-1:0][OUT_W-1:0] yn;

  always_comb begin
    xc[0] = e0 + e1;
    xc[4] = sr(e0, SH1) - sr(e1, SH1);
    xc[6] = e2 - sr(e3, SH2) - sr(e3, SH3);
    xc[2] = sr(e2, SH2) + sr(e2, SH3) + e3 - sr(e3, SH3) - sr(e3, SH6);
    xc[7] = o4 - sr(o7, SH3);
    xc[5] = o5 + o6 - sr(o6, SH3);
    xc[3] = sr(o6, SH1) + sr(o6, SH4) - sr(o5, SH1);
    xc[1] = o7;
    for (int k = 0; k < N_PTS; k++) xv[k] = MAX_W'(xc[k]);
  end

`ifdef IC_BD_SAT_EN
  logic [N_PTS-1:0] cl;
  logic             sat_l;
`endif

  for (genvar k = 0; k < N_PTS; k++) begin : g_lane
    ic_bd_narrow #(.OUT_W(OUT_W)) u_narrow (
      .d     (xv[k]),
      .q     (yn[k])
`ifdef IC_BD_SAT_EN
      ,
      .clamp (cl[k])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      y         <= '0;
    end else if (en) begin
      out_valid <= s2_v;
      out_last  <= s2_l;
      y         <= yn;
    end
  end

`ifdef IC_BD_SAT_EN
  // Only clamps on vectors that actually leave the block make the flag stick.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_l    <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (en) sat_l <= |cl;
      if (out_valid && out_ready && sat_l) sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ic_bd_bindct_1d_pipe.sv
// Directed bench for ic_bd_bindct_1d_pipe across row, level-shift, narrow and column configurations.
// Clamp expectations follow IC_BD_SAT_EN.
module tb_ic_bd_bindct_1d_pipe;

  logic clk, reset, in_valid, in_last, out_ready;
  logic [63:0]  x_a, x_b;
  logic [95:0]  x_d;
  logic ir_a, ov_a, ol_a, ir_b, ov_b, ol_b, ir_c, ov_c, ol_c, ir_d, ov_d, ol_d;
  logic [95:0]  y_a, y_b;
  logic [79:0]  y_c;
  logic [127:0] y_d;
`ifdef IC_BD_SAT_EN
  logic sat_a, sat_b, sat_c, sat_d;
`endif

  int checks   = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  ic_bd_bindct_1d_pipe #(.IN_W(8), .LVL_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a), .in_last(in_last), .x(x_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_last(ol_a), .y(y_a)
`ifdef IC_BD_SAT_EN
    , .sat_flag(sat_a)
`endif
  );

  ic_bd_bindct_1d_pipe #(.IN_W(8), .LVL_SHIFT(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_b), .in_last(in_last), .x(x_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_last(ol_b), .y(y_b)
`ifdef IC_BD_SAT_EN
    , .sat_flag(sat_b)
`endif
  );

  ic_bd_bindct_1d_pipe #(.IN_W(8), .OUT_W(10), .LVL_SHIFT(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_c), .in_last(in_last), .x(x_b),
    .out_valid(ov_c), .out_ready(out_ready), .out_last(ol_c), .y(y_c)
`ifdef IC_BD_SAT_EN
    , .sat_flag(sat_c)
`endif
  );

  ic_bd_bindct_1d_pipe #(.IN_W(12), .OUT_W(16), .LVL_SHIFT(0)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d), .in_last(in_last), .x(x_d),
    .out_valid(ov_d), .out_ready(out_ready), .out_last(ol_d), .y(y_d)
`ifdef IC_BD_SAT_EN
    , .sat_flag(sat_d)
`endif
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int sel, input int e [8]);
    int obs;
    for (int k = 0; k < 8; k++) begin
      case (sel)
        0:       obs = int'($signed(y_a[k*12 +: 12]));
        1:       obs = int'($signed(y_b[k*12 +: 12]));
        2:       obs = int'($signed(y_c[k*10 +: 10]));
        default: obs = int'($signed(y_d[k*16 +: 16]));
      endcase
      check($sformatf("%s_X%0d", tag, k), obs, e[k]);
    end
  endtask

  function automatic logic [63:0] fill8(input logic [7:0] v);
    return {8{v}};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; leaves the bench at the falling edge where the result is visible.
  task automatic send();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sent;
    int got;
    logic [12:0] e;

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    x_a = '0; x_b = '0; x_d = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;

    check("rst_ov_a", int'(ov_a), 0);
    check("rst_ol_a", int'(ol_a), 0);
    check("rst_y_a",  int'(|y_a), 0);
    check("rst_ir_a", int'(ir_a), 1);
    check("rst_ir_bcd", int'(ir_b && ir_c && ir_d), 1);
    check("rst_ov_bcd", int'(ov_b || ov_c || ov_d || ol_b || ol_c || ol_d), 0);
    check("rst_y_bcd",  int'(|y_b || |y_c || |y_d), 0);
`ifdef IC_BD_SAT_EN
    check("rst_sat", int'(sat_a || sat_b || sat_c || sat_d), 0);
`endif

    @(negedge clk);
    x_a = fill8(8'd1);
    send();
    check("ones_ov", int'(ov_a), 1);
    chk_vec("ones", 0, '{8, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    check("bubble_ov", int'(ov_a), 0);

    x_a = 64'h40;
    send();
    chk_vec("imp0", 0, '{64, 64, 55, 36, 32, 56, -24, -8});

    x_a = fill8(8'hFF);
    send();
    chk_vec("neg1", 0, '{-8, 0, 0, 0, 0, 0, 0, 0});

    x_a = 64'h4000;
    send();
    chk_vec("imp1", 0, '{64, 64, 24, -16, -32, -96, 64, 32});

    x_a = 64'h40_0000;
    send();
    chk_vec("imp2", 0, '{64, 24, -24, -38, -32, 28, -64, -52});

    x_a = 64'h2000_0000;
    send();
    chk_vec("imp3", 0, '{32, 0, -27, -16, 16, 32, 12, 32});

    x_b = fill8(8'd128);
    send();
    chk_vec("lvl128_b", 1, '{0, 0, 0, 0, 0, 0, 0, 0});
    chk_vec("lvl128_c", 2, '{0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
`ifdef IC_BD_SAT_EN
    check("lvl128_sat_c", int'(sat_c), 0);
`endif

    x_b = fill8(8'd255);
    send();
    chk_vec("lvl255_b", 1, '{1016, 0, 0, 0, 0, 0, 0, 0});
`ifdef IC_BD_SAT_EN
    chk_vec("lvl255_c", 2, '{511, 0, 0, 0, 0, 0, 0, 0});
`else
    chk_vec("lvl255_c", 2, '{-8, 0, 0, 0, 0, 0, 0, 0});
`endif
    @(negedge clk);
`ifdef IC_BD_SAT_EN
    check("lvl255_sat_c", int'(sat_c), 1);
    check("lvl255_sat_b", int'(sat_b), 0);
`endif

    // Backpressure: out_ready toggles every cycle while ten vectors stream through dut_a.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = cyc[0];
      if (sent < 10) begin
        in_valid = 1'b1;
        in_last  = (sent == 7);
        x_a      = fill8(8'(sent + 1));
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      check("bp_in_ready", int'(ir_a), int'(!(ov_a && !out_ready)));
      if (ov_a && out_ready) begin
        check("bp_q_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("bp_y0",   int'($signed(y_a[11:0])), int'($signed(e[11:0])));
          check("bp_rest", int'(|y_a[95:12]), 0);
          check("bp_last", int'(ol_a), int'(e[12]));
        end
        got++;
      end
      if (in_valid && ir_a) begin
        exp_q.push_back({in_last, 12'(8 * (sent + 1))});
        sent++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 10);
    check("bp_q_empty", exp_q.size(), 0);

    // Reset with three vectors in flight.
    @(negedge clk);
    x_a = fill8(8'd1); in_valid = 1'b1;
    @(negedge clk);
    x_a = fill8(8'd2);
    @(negedge clk);
    x_a = fill8(8'd3);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_ov", int'(ov_a), 0);
    check("mid_rst_y",  int'(|y_a), 0);
    check("mid_rst_ol", int'(ol_a), 0);
    check("mid_rst_ir", int'(ir_a), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("no_stale_%0d", i), int'(ov_a), 0);
    end

    // Column pass, 12-bit input.
    x_d = 96'd2047;
    send();
    check("col_ov", int'(ov_d), 1);
    chk_vec("col", 3, '{2047, 2047, 1761, 1150, 1023, 1792, -766, -255});

    x_a = 64'h40;
    send();
    chk_vec("post_rst_imp0", 0, '{64, 64, 55, 36, 32, 56, -24, -8});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ic_bd_bindct_1d_pipe.md
Name: ic_bd_bindct_1d_pipe

Overview:
Parametrised, fully pipelined 8-point forward 1-D BinDCT-C7 stage for the JPEG compression path. It uses the same lifting/butterfly arithmetic as the existing fixed 8-bit stage, with these additions:
- generic input width, so one block serves row pass (8-bit) and column pass (12-bit);
- optional unsigned level shift on input;
- valid/ready backpressure on both sides;
- a block-end sideband.
It sits between the block buffer and the transpose memory or quantiser.

Parameters:
IN_W, 8, input sample width in bits
OUT_W, IN_W+4, output coefficient width in bits; signed two's complement
LVL_SHIFT, 0, 1 = inputs are unsigned and are level-shifted by -2^(IN_W-1); 0 = inputs are signed

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block accepts the vector this cycle
in_last  in  1  last row of an 8x8 block; sideband
x  in  8*IN_W  samples; x[k] = x[(k+1)*IN_W-1 : k*IN_W]
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts
out_last  out  1  delayed in_last
y  out  8*OUT_W  coefficients in natural order; y[k] = X_k

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on the port named reset. Reset clears all stage valid bits, out_valid=0, out_last=0, y=0. Reset asserted mid-operation discards every in-flight vector. The first cycle after reset already has in_ready=1.
- Internal width: IW = IN_W+4. Samples are sign-extended to IW; with LVL_SHIFT=1 they are zero-extended and 2^(IN_W-1) is subtracted first.
- asr(v,n) = arithmetic shift right, i.e. floor. All sums are IW-bit, wrap-free by construction.
- Pipeline: 3 register stages, each with a valid bit and a last bit. Global enable en = !out_valid | out_ready. in_ready = en. A transfer occurs when in_valid & in_ready. When en=0 all stages hold. Bubbles are not squeezed.
- Latency: 3 cycles when out_ready stays high. Throughput: 1 vector per cycle.
- S1 (capture): a0=x0+x7, a7=x0-x7, a1=x1+x6, a6=x1-x6, a2=x2+x5, a5=x2-x5, a3=x3+x4, a4=x3-x4. The stage valid bit is loaded with the transfer strobe.
- S2, combinational lifting from S1 registers:
  - t15 = asr(a6,1)+asr(a6,3)-asr(a5,1)-asr(a5,2)-asr(a5,6)
  - t16 = a6+asr(a5,2)+asr(a5,3)
  - registered: e0=a0+a3, e1=a1+a2, e2=a1-a2, e3=a0-a3, o4=a4+t15, o5=a4-t15, o6=a7-t16, o7=a7+t16
- S3 (output registers):
  - X0 = e0+e1
  - X4 = asr(e0,1)-asr(e1,1)
  - X6 = e2-asr(e3,2)-asr(e3,3)
  - X2 = asr(e2,2)+asr(e2,3)+e3-asr(e3,3)-asr(e3,6)
  - X7 = o4-asr(o7,3)
  - X5 = o5+o6-asr(o6,3)
  - X3 = asr(o6,1)+asr(o6,4)-asr(o5,1)
  - X1 = o7
- Output narrowing IW to OUT_W: keep the low OUT_W bits (wrap). When OUT_W >= IW, sign-extend.
- Output stability: y and out_last are stable while out_valid & !out_ready.
- Simultaneous input accept and output drain in the same cycle is legal and keeps full rate.

Optional Feature:
IC_BD_SAT_EN
- Defined: when narrowing IW to OUT_W, clamp each coefficient to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Add output port sat_flag (1 bit): a sticky OR of any clamp event on transferred outputs, cleared only by reset.
- Undefined: truncating wrap as above; port sat_flag is absent.

Decomposition:
- Package ic_bd_pkg holds:
  - constants N_PTS=8 and the lifting shift amounts (1,2,3,4,6);
  - a function for asr on IW-wide values;
  - a typedef for the 8-lane coefficient vector.
- One natural sub-module: ic_bd_narrow, which does per-lane IW to OUT_W wrap/saturate and raises the clamp indication. It is instantiated 8 times.

Test Plan:
1. IN_W=8, LVL_SHIFT=0, x all = 1, out_ready=1 -> after 3 cycles y = {8,0,0,0,0,0,0,0}.
2. Impulse x0=64, others 0 -> X0..X7 = 64, 64, 55, 36, 32, 56, -24, -8.
3. x all = -1 -> X0 = -8, X1..X7 = 0 (checks floor shifts on negatives).
4. LVL_SHIFT=1:
   - all x = 128 -> all outputs 0;
   - all x = 255 -> X0 = 1016, rest 0.
   - With OUT_W=10, same vector: IC_BD_SAT_EN off -> X0 = -8; on -> X0 = 511 and sat_flag = 1.
5. Backpressure: stream 10 vectors with in_last on the 8th, toggling out_ready 1/0 every cycle ->
   - no loss or duplication, order preserved;
   - in_ready low exactly when out_valid & !out_ready;
   - out_last set on the 8th output only.
6. Reset asserted for 1 cycle with 3 vectors in flight -> next cycle out_valid = 0, y = 0, and no stale vector appears afterwards. IN_W=12 column pass with x0=2047 gives X0 = 2047 at OUT_W=16.
